if_stage: RTL and testbench

- Instruction-fetch stage of the 8-bit CPU. It sits between the program-counter register and decode.
- Reads the current PC, issues a request to instruction memory, and captures the returned word into the IF/ID register with a valid flag.
- Computes the next-PC value that the PC register latches on every clkin edge.
- Handles decode back-pressure (stall) and branch redirect (flush), with a one-entry hold buffer so a memory response is never lost.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_hold_buf.sv | 40 ++++
 rtl/if_stage.sv | 163 ++++++++++++++++
 tb/tb_if_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU pipeline.
//   ADDR_W     : PC / instruction-memory address width
//   INSTR_W    : instruction word width
//   if_state_t : fetch-stage FSM encoding, also decoded by the debug/trace block
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // first cycle after reset release, no request
    S_REQ  = 2'd1,  // request outstanding to instruction memory
    S_HOLD = 2'd2   // returned word parked in the hold buffer
  } if_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction + PC buffer used by the fetch stage to park a memory
// response while decode is stalled.
//   clkin, reset       : clock, asynchronous active-high reset
//   load               : capture din_instr / din_pc, set valid
//   clear              : drop the entry (wins over load)
//   din_instr, din_pc  : word and its address to capture
//   valid              : entry holds a live word
//   dout_instr, dout_pc: stored word and its address
module if_hold_buf #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] din_instr,
  input  logic [ADDR_W-1:0]  din_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] dout_instr,
  output logic [ADDR_W-1:0]  dout_pc
);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      dout_instr <= '0;
      dout_pc    <= '0;
    end else if (clear) begin
      valid      <= 1'b0;
      dout_instr <= '0;
      dout_pc    <= '0;
    end else if (load) begin
      valid      <= 1'b1;
      dout_instr <= din_instr;
      dout_pc    <= din_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 8-bit CPU. Requests the word at pc_in from
// instruction memory, captures it into the IF/ID register and produces the
// next PC for the PC register. A one-entry hold buffer absorbs a response
// that arrives while decode is stalled with a full IF/ID register.
//
// Memory handshake: mem_req is the valid, mem_ready the ready; a word moves
// only in a cycle where both are 1, and that transfer is taken (accepted)
// only if no redirect is present in the same cycle.
//
// Ports:
//   clkin, reset                 : clock, asynchronous active-high reset
//   pc_in / pc_next              : PC register output / next value (comb)
//   mem_req, mem_addr            : instruction-memory request and address
//   mem_rdata, mem_ready         : returned word and completion strobe
//   stall_in                     : decode cannot take a new instruction
//   redir_valid, redir_target    : taken branch/jump, flushes the fetch path
//   ifid_valid/instr/pc          : IF/ID register
//   perf_fetch, perf_stall       : saturating counters (IF_PERF_CNT_EN only)
//   dbg_state                    : current FSM state for trace/debug
//
// Build option: define IF_PERF_CNT_EN to add the performance counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  input  logic               stall_in,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]        perf_fetch,
  output logic [15:0]        perf_stall,
`endif
  output if_state_t          dbg_state
);

  if_state_t state, state_nx;

  logic               accept;
  logic               out_free;
  logic               hold_load;
  logic               hold_unload;
  logic               hold_clear;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;

  // A response counts only while requesting and not being flushed.
  assign accept      = (state == S_REQ) && mem_ready && !redir_valid;
  // IF/ID can take a word if it is empty or decode is consuming it now.
  assign out_free    = !ifid_valid || !stall_in;
  assign hold_load   = accept && !out_free;
  assign hold_unload = (state == S_HOLD) && hold_valid && !stall_in && !redir_valid;
  assign hold_clear  = redir_valid || hold_unload;

  assign mem_addr = pc_in;

  // Redirect first; otherwise advance only on an accepted fetch.
  always_comb begin
    pc_next = pc_in;
    if (redir_valid) begin
      pc_next = redir_target;
    end else if (accept) begin
      pc_next = pc_in + ADDR_W'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (redir_valid) begin
      state_nx = S_REQ;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_REQ;
        S_REQ:   if (hold_load) state_nx = S_HOLD;
        S_HOLD:  if (!stall_in) state_nx = S_REQ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    mem_req   = (state == S_REQ);
    dbg_state = state;
  end

  // IF/ID register
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (redir_valid) begin
      ifid_valid <= 1'b0;
    end else if (accept && out_free) begin
      ifid_valid <= 1'b1;
      ifid_instr <= mem_rdata;
      ifid_pc    <= pc_in;
    end else if (hold_unload) begin
      ifid_valid <= 1'b1;
      ifid_instr <= hold_instr;
      ifid_pc    <= hold_pc;
    end else if (!stall_in) begin
      ifid_valid <= 1'b0;
    end
  end

  if_hold_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_hold (
    .clkin      (clkin),
    .reset      (reset),
    .load       (hold_load),
    .clear      (hold_clear),
    .din_instr  (mem_rdata),
    .din_pc     (pc_in),
    .valid      (hold_valid),
    .dout_instr (hold_instr),
    .dout_pc    (hold_pc)
  );

`ifdef IF_PERF_CNT_EN
  // Saturating counters; nothing is counted in S_IDLE.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else if (state != S_IDLE) begin
      if (accept && (perf_fetch != 16'hFFFF)) begin
        perf_fetch <= perf_fetch + 16'd1;
      end
      if (ifid_valid && stall_in && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: drives a PC register and a zero/variable-wait
// instruction memory returning 16'h1000 + address, runs directed scenarios,
// then a randomized run checked against a queue-based delivery model.
module tb_if_stage;
  import cpu_pkg::*;

  logic        clkin;
  logic        reset;
  logic [7:0]  pc_reg;
  logic [7:0]  pc_next;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall_in;
  logic        redir_valid;
  logic [7:0]  redir_target;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  if_state_t   dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch;
  logic [15:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clkin        (clkin),
    .reset        (reset),
    .pc_in        (pc_reg),
    .pc_next      (pc_next),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .stall_in     (stall_in),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
`ifdef IF_PERF_CNT_EN
    .perf_fetch   (perf_fetch),
    .perf_stall   (perf_stall),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  // PC register fed by pc_next
  always @(posedge clkin or posedge reset) begin
    if (reset) pc_reg <= 8'h00;
    else       pc_reg <= pc_next;
  end

  // Instruction memory content: word = 16'h1000 + address
  assign mem_rdata = 16'h1000 + {8'h00, mem_addr};

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(negedge clkin);
  endtask

  task automatic clear_inputs();
    mem_ready    = 1'b0;
    stall_in     = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 8'h00;
  endtask

  // Leaves time at the negedge that opens the S_IDLE cycle.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nxt();
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", ifid_valid); end
    n_cmp++; if (ifid_instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr: got %h exp 0000", ifid_instr); end
    n_cmp++; if (ifid_pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h exp 00", ifid_pc); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, S_IDLE); end
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_mem_req: got %b exp 0", mem_req); end
    n_cmp++; if (pc_next !== 8'h00) begin n_err++; $display("FAIL idle_pc_next: got %h exp 00", pc_next); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL str_idle: got %0d exp %0d", dbg_state, S_IDLE); end
    n_cmp++; if (pc_next !== 8'h00) begin n_err++; $display("FAIL str_idle_pcn: got %h exp 00", pc_next); end
    nxt(); #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin n_err++; $display("FAIL str_req0: got req %b addr %h exp 1 00", mem_req, mem_addr); end
    n_cmp++; if (pc_next !== 8'h01) begin n_err++; $display("FAIL str_pcn0: got %h exp 01", pc_next); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL str_valid0: got %b exp 0", ifid_valid); end
    for (int k = 0; k < 5; k++) begin
      nxt(); #1;
      n_cmp++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 8'(k) || ifid_instr !== 16'h1000 + 16'(k) || pc_next !== 8'(k + 2)) begin
        n_err++;
        $display("FAIL str_word%0d: got v%b pc %h instr %h pcn %h exp v1 pc %h instr %h pcn %h",
                 k, ifid_valid, ifid_pc, ifid_instr, pc_next, 8'(k), 16'h1000 + 16'(k), 8'(k + 2));
      end
    end
  endtask

  task automatic test_wrap();
    nxt();
    redir_valid = 1'b1; redir_target = 8'hFF;
    #1;
    n_cmp++; if (pc_next !== 8'hFF) begin n_err++; $display("FAIL wrap_redir: got %h exp ff", pc_next); end
    nxt();
    redir_valid = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 8'hFF || pc_next !== 8'h00) begin n_err++; $display("FAIL wrap_pcn: got addr %h pcn %h exp ff 00", mem_addr, pc_next); end
    nxt(); #1;
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'hFF || ifid_instr !== 16'h10FF) begin n_err++; $display("FAIL wrap_ifid: got v%b pc %h instr %h exp v1 ff 10ff", ifid_valid, ifid_pc, ifid_instr); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL wrap_addr: got %h exp 00", mem_addr); end
  endtask

  task automatic test_stall_hold();
    nxt();
    redir_valid = 1'b1; redir_target = 8'h20; stall_in = 1'b0; mem_ready = 1'b1;
    nxt();
    redir_valid = 1'b0;
    #1;
    n_cmp++; if (ifid_valid !== 1'b0 || mem_addr !== 8'h20 || pc_next !== 8'h21) begin n_err++; $display("FAIL sh_start: got v%b addr %h pcn %h exp v0 20 21", ifid_valid, mem_addr, pc_next); end
    nxt();
    stall_in = 1'b1;
    #1;
    n_cmp++; if (ifid_pc !== 8'h20 || mem_addr !== 8'h21 || pc_next !== 8'h22) begin n_err++; $display("FAIL sh_park: got pc %h addr %h pcn %h exp 20 21 22", ifid_pc, mem_addr, pc_next); end
    for (int k = 0; k < 2; k++) begin
      nxt(); #1;
      n_cmp++;
      if (dbg_state !== S_HOLD || mem_req !== 1'b0 || pc_next !== 8'h22 || ifid_pc !== 8'h20 || ifid_valid !== 1'b1) begin
        n_err++;
        $display("FAIL sh_hold%0d: got st %0d req %b pcn %h pc %h v%b exp st %0d req 0 pcn 22 pc 20 v1",
                 k, dbg_state, mem_req, pc_next, ifid_pc, ifid_valid, S_HOLD);
      end
    end
    nxt();
    stall_in = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== S_HOLD || ifid_pc !== 8'h20 || mem_req !== 1'b0 || pc_next !== 8'h22) begin n_err++; $display("FAIL sh_release: got st %0d pc %h req %b pcn %h", dbg_state, ifid_pc, mem_req, pc_next); end
    nxt(); #1;
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h21 || ifid_instr !== 16'h1021) begin n_err++; $display("FAIL sh_second: got v%b pc %h instr %h exp v1 21 1021", ifid_valid, ifid_pc, ifid_instr); end
    n_cmp++; if (dbg_state !== S_REQ || mem_addr !== 8'h22 || pc_next !== 8'h23) begin n_err++; $display("FAIL sh_resume: got st %0d addr %h pcn %h exp %0d 22 23", dbg_state, mem_addr, pc_next, S_REQ); end
    nxt(); #1;
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h22) begin n_err++; $display("FAIL sh_third: got v%b pc %h exp v1 22", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect();
    nxt();
    redir_valid = 1'b1; redir_target = 8'h40; mem_ready = 1'b1;
    #1;
    n_cmp++; if (pc_next !== 8'h40) begin n_err++; $display("FAIL rd_pcn: got %h exp 40", pc_next); end
    nxt();
    redir_valid = 1'b0;
    #1;
    n_cmp++; if (ifid_valid !== 1'b0 || mem_addr !== 8'h40) begin n_err++; $display("FAIL rd_flush: got v%b addr %h exp v0 40", ifid_valid, mem_addr); end
    nxt(); #1;
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h40 || ifid_instr !== 16'h1040) begin n_err++; $display("FAIL rd_target: got v%b pc %h instr %h exp v1 40 1040", ifid_valid, ifid_pc, ifid_instr); end
  endtask

  task automatic test_wait_reset();
    nxt();
    redir_valid = 1'b1; redir_target = 8'h60; mem_ready = 1'b0; stall_in = 1'b0;
    nxt();
    redir_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h60 || pc_next !== 8'h60) begin
        n_err++;
        $display("FAIL wt_wait%0d: got req %b addr %h pcn %h exp 1 60 60", k, mem_req, mem_addr, pc_next);
      end
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (mem_addr !== 8'h60 || pc_next !== 8'h61) begin n_err++; $display("FAIL wt_done: got addr %h pcn %h exp 60 61", mem_addr, pc_next); end
    nxt();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 8'h60 || mem_addr !== 8'h61 || pc_next !== 8'h61) begin n_err++; $display("FAIL wt_word: got v%b pc %h addr %h pcn %h exp v1 60 61 61", ifid_valid, ifid_pc, mem_addr, pc_next); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || ifid_pc !== 8'h00) begin n_err++; $display("FAIL wt_async_rst: got v%b instr %h pc %h exp 0 0000 00", ifid_valid, ifid_instr, ifid_pc); end
    n_cmp++; if (dbg_state !== S_IDLE || mem_req !== 1'b0) begin n_err++; $display("FAIL wt_rst_state: got st %0d req %b exp %0d 0", dbg_state, mem_req, S_IDLE); end
    nxt();
    reset = 1'b0;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (perf_fetch !== 16'd0 || perf_stall !== 16'd0) begin n_err++; $display("FAIL perf_reset: got %0d %0d exp 0 0", perf_fetch, perf_stall); end
    repeat (5) nxt();
    nxt();
    mem_ready = 1'b0; stall_in = 1'b1;
    nxt();
    nxt();
    nxt();
    stall_in = 1'b0;
    #1;
    n_cmp++; if (perf_fetch !== 16'd5) begin n_err++; $display("FAIL perf_fetch: got %0d exp 5", perf_fetch); end
    n_cmp++; if (perf_stall !== 16'd3) begin n_err++; $display("FAIL perf_stall: got %0d exp 3", perf_stall); end
  endtask
`endif

  // Randomized run. Reference: the words fetched but not yet consumed by
  // decode form a FIFO of at most two entries; fetch addresses follow a
  // sequential pointer that jumps on a redirect.
  task automatic test_random();
    logic [23:0] exp_q[$];
    logic [7:0]  fptr;
    logic [7:0]  exp_next;
    bit          idle;
    bit          exp_req;
    bit          hs;
    int          m_fetch;
    int          m_stall;
    do_reset();
    fptr = 8'h00; idle = 1'b1; m_fetch = 0; m_stall = 0;
    for (int c = 0; c < 1500; c++) begin
      stall_in     = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      redir_valid  = ($urandom_range(0, 15) == 0);
      redir_target = 8'($urandom);
      #1;
      exp_req  = !idle && (exp_q.size() < 2);
      hs       = exp_req && mem_ready && !redir_valid;
      exp_next = redir_valid ? redir_target : (hs ? fptr + 8'd1 : fptr);
      n_cmp++; if (mem_req !== exp_req) begin n_err++; $display("FAIL rnd_req c%0d: got %b exp %b", c, mem_req, exp_req); end
      if (exp_req) begin
        n_cmp++; if (mem_addr !== fptr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h exp %h", c, mem_addr, fptr); end
      end
      n_cmp++; if (pc_next !== exp_next) begin n_err++; $display("FAIL rnd_pcn c%0d: got %h exp %h", c, pc_next, exp_next); end
      n_cmp++; if (ifid_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, ifid_valid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        n_cmp++;
        if ({ifid_pc, ifid_instr} !== exp_q[0]) begin
          n_err++;
          $display("FAIL rnd_ifid c%0d: got %h/%h exp %h/%h", c, ifid_pc, ifid_instr, exp_q[0][23:16], exp_q[0][15:0]);
        end
      end
`ifdef IF_PERF_CNT_EN
      n_cmp++; if (perf_fetch !== 16'(m_fetch) || perf_stall !== 16'(m_stall)) begin n_err++; $display("FAIL rnd_perf c%0d: got %0d %0d exp %0d %0d", c, perf_fetch, perf_stall, m_fetch, m_stall); end
      if (hs) m_fetch++;
      if (!idle && exp_q.size() > 0 && stall_in) m_stall++;
`endif
      if (redir_valid) begin
        exp_q.delete();
        fptr = redir_target;
      end else begin
        if (exp_q.size() > 0 && !stall_in) void'(exp_q.pop_front());
        if (hs) begin
          exp_q.push_back({fptr, 16'h1000 + {8'h00, fptr}});
          fptr = fptr + 8'd1;
        end
      end
      idle = 1'b0;
      nxt();
    end
    clear_inputs();
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_stream();
    test_wrap();
    test_stall_hold();
    test_redirect();
    test_wait_reset();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
